// File: rtl/alu_slice_seq.sv
// Nibble-serial 74181-style ALU: one 4-bit slice per cycle, valid/ready handshakes
// on both sides, flags (carry, overflow, A==B, zero) accumulated across slices.
module alu_slice_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             ovf,
  output logic             a_eq_b,
  output logic             zero
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             eq_q, eq_d, zr_q, zr_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d;
  logic             a_eq_b_q, a_eq_b_d, zero_q, zero_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [3:0] an, bn, p, q, lnib, nib;
  logic [4:0] sum5;
  logic       c3, cout_s;

  // Current slice: logic function and adder operands selected by s
  always_comb begin
    an = a_q[{k_q, 2'b00} +: 4];
    bn = b_q[{k_q, 2'b00} +: 4];
    p    = an;
    q    = 4'h0;
    lnib = 4'h0;
    case (s_q)
      4'h0: begin lnib = ~an;        p = an;        q = 4'h0;     end
      4'h1: begin lnib = ~(an | bn); p = an | bn;   q = 4'h0;     end
      4'h2: begin lnib = ~an & bn;   p = an | ~bn;  q = 4'h0;     end
      4'h3: begin lnib = 4'h0;       p = 4'hF;      q = 4'h0;     end
      4'h4: begin lnib = ~(an & bn); p = an;        q = an & ~bn; end
      4'h5: begin lnib = ~bn;        p = an | bn;   q = an & ~bn; end
      4'h6: begin lnib = an ^ bn;    p = an;        q = ~bn;      end
      4'h7: begin lnib = an & ~bn;   p = an & ~bn;  q = 4'hF;     end
      4'h8: begin lnib = ~an | bn;   p = an;        q = an & bn;  end
      4'h9: begin lnib = ~(an ^ bn); p = an;        q = bn;       end
      4'hA: begin lnib = bn;         p = an | ~bn;  q = an & bn;  end
      4'hB: begin lnib = an & bn;    p = an & bn;   q = 4'hF;     end
      4'hC: begin lnib = 4'hF;       p = an;        q = an;       end
      4'hD: begin lnib = an | ~bn;   p = an | bn;   q = an;       end
      4'hE: begin lnib = an | bn;    p = an | ~bn;  q = an;       end
      default: begin lnib = an;      p = an;        q = 4'hF;     end
    endcase
    sum5   = 5'(p) + 5'(q) + 5'(cy_q);
    c3     = p[3] ^ q[3] ^ sum5[3];
    nib    = m_q ? lnib : sum5[3:0];
    cout_s = m_q ? 1'b0 : sum5[4];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    m_d         = m_q;
    cy_d        = cy_q;
    acc_d       = acc_q;
    eq_d        = eq_q;
    zr_d        = zr_q;
    f_d         = f_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    a_eq_b_d    = a_eq_b_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          cy_d    = c_in;
          k_d     = '0;
          eq_d    = 1'b1;
          zr_d    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[{k_q, 2'b00} +: 4] = nib;
        cy_d = cout_s;
        eq_d = eq_q & (an == bn);
        zr_d = zr_q & (nib == 4'h0);
        k_d  = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d  = DONE;
          k_d      = '0;
          f_d      = acc_d;
          c_out_d  = cout_s;
          ovf_d    = m_q ? 1'b0 : (c3 ^ sum5[4]);
          a_eq_b_d = eq_d;
          zero_d   = zr_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      cy_q        <= 1'b0;
      acc_q       <= '0;
      eq_q        <= 1'b0;
      zr_q        <= 1'b0;
      f_q         <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      a_eq_b_q    <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      m_q         <= m_d;
      cy_q        <= cy_d;
      acc_q       <= acc_d;
      eq_q        <= eq_d;
      zr_q        <= zr_d;
      f_q         <= f_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      a_eq_b_q    <= a_eq_b_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign a_eq_b    = a_eq_b_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Bench for alu_slice_seq: full-width arithmetic reference model checked every cycle
// on an 8-bit instance, plus directed vectors and a mid-operation reset on a 16-bit one.
module tb_alu_slice_seq;

  typedef struct packed {
    logic [63:0] f;
    logic        c;
    logic        v;
    logic        eq;
    logic        z;
  } res_t;

  localparam int NIB8 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst16_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a8 = '0, b8 = '0, f8;
  logic [3:0]  s8 = '0;
  logic        m8 = 1'b0, c8 = 1'b0, iv8 = 1'b0, or8 = 1'b0;
  logic        ir8, ov8, co8, vf8, eq8, z8;

  logic [15:0] a16 = '0, b16 = '0, f16;
  logic [3:0]  s16 = '0;
  logic        m16 = 1'b0, c16 = 1'b0, iv16 = 1'b0, or16 = 1'b0;
  logic        ir16, ov16, co16, vf16, eq16, z16;

  alu_slice_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .s(s8), .m(m8), .c_in(c8),
    .in_valid(iv8), .in_ready(ir8), .out_valid(ov8), .out_ready(or8),
    .f(f8), .c_out(co8), .ovf(vf8), .a_eq_b(eq8), .zero(z8));

  alu_slice_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .a(a16), .b(b16), .s(s16), .m(m16), .c_in(c16),
    .in_valid(iv16), .in_ready(ir16), .out_valid(ov16), .out_ready(or16),
    .f(f16), .c_out(co16), .ovf(vf16), .a_eq_b(eq16), .zero(z16));

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [63:0] f, input logic c, v, eq, z);
    res_t r;
    r.f = f; r.c = c; r.v = v; r.eq = eq; r.z = z;
    return r;
  endfunction

  // Whole-word reference: bitwise logic table, or P + Q + c_in with full-width flags
  function automatic res_t ref_alu(input int w, input logic [63:0] ai, bi,
                                   input logic [3:0] s, input logic m, input logic cin);
    logic [63:0] mask, a, b, p, q, lf;
    logic [64:0] sum;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    a = ai & mask;
    b = bi & mask;
    r = '0;
    r.eq = (a == b);
    p = a; q = '0; lf = '0;
    if (m) begin
      case (s)
        4'h0: lf = ~a;        4'h1: lf = ~(a | b); 4'h2: lf = ~a & b;    4'h3: lf = '0;
        4'h4: lf = ~(a & b);  4'h5: lf = ~b;       4'h6: lf = a ^ b;     4'h7: lf = a & ~b;
        4'h8: lf = ~a | b;    4'h9: lf = ~(a ^ b); 4'hA: lf = b;         4'hB: lf = a & b;
        4'hC: lf = '1;        4'hD: lf = a | ~b;   4'hE: lf = a | b;     default: lf = a;
      endcase
      r.f = lf & mask;
    end else begin
      case (s)
        4'h0: begin p = a;      q = '0;     end
        4'h1: begin p = a | b;  q = '0;     end
        4'h2: begin p = a | ~b; q = '0;     end
        4'h3: begin p = '1;     q = '0;     end
        4'h4: begin p = a;      q = a & ~b; end
        4'h5: begin p = a | b;  q = a & ~b; end
        4'h6: begin p = a;      q = ~b;     end
        4'h7: begin p = a & ~b; q = '1;     end
        4'h8: begin p = a;      q = a & b;  end
        4'h9: begin p = a;      q = b;      end
        4'hA: begin p = a | ~b; q = a & b;  end
        4'hB: begin p = a & b;  q = '1;     end
        4'hC: begin p = a;      q = a;      end
        4'hD: begin p = a | b;  q = a;      end
        4'hE: begin p = a | ~b; q = a;      end
        default: begin p = a;   q = '1;     end
      endcase
      p &= mask;
      q &= mask;
      sum = {1'b0, p} + {1'b0, q} + 65'(cin);
      r.f = sum[63:0] & mask;
      r.c = sum[w];
      r.v = (p[w-1] == q[w-1]) && (r.f[w-1] != p[w-1]);
    end
    r.z = (r.f == '0);
    return r;
  endfunction

  function automatic res_t pack8();
    return mk(64'(f8), co8, vf8, eq8, z8);
  endfunction

  function automatic res_t pack16();
    return mk(64'(f16), co16, vf16, eq16, z16);
  endfunction

  // Transaction-level model of the 8-bit instance: latency NIB8, hold until out_ready
  bit   md_busy = 1'b0, md_done = 1'b0;
  int   md_cnt = 0;
  res_t md_pend = '0, md_exp = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy <= 1'b0; md_done <= 1'b0; md_cnt <= 0; md_exp <= '0;
    end else if (md_busy) begin
      md_cnt <= md_cnt + 1;
      if (md_cnt + 1 == NIB8) begin
        md_busy <= 1'b0; md_done <= 1'b1; md_exp <= md_pend;
      end
    end else if (md_done) begin
      if (or8) md_done <= 1'b0;
    end else if (iv8) begin
      md_busy <= 1'b1; md_cnt <= 0;
      md_pend <= ref_alu(8, 64'(a8), 64'(b8), s8, m8, c8);
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on)
      chk("cycle8", 80'({ir8, ov8, pack8()}), 80'({!md_busy && !md_done, md_done, md_exp}));
  end

  task automatic garbage8();
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 4'($urandom);
    m8 = 1'($urandom); c8 = 1'($urandom); iv8 = 1'($urandom_range(0, 1));
  endtask

  task automatic run8(input logic [7:0] ta, tbv, input logic [3:0] ts, input logic tm, tc,
                      input int hold, input bit use_hexp, input res_t hexp,
                      output res_t got, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    if (!ir8) chk("accept_timeout8", 80'(ir8), 80'(1));
    a8 = ta; b8 = tbv; s8 = ts; m8 = tm; c8 = tc; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk); garbage8();
    while (!ov8 && lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk); garbage8();
    end
    if (!ov8) chk("done_timeout8", 80'(ov8), 80'(1));
    got = pack8();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk); garbage8();
      iv8 = 1'b1;
      if (use_hexp) begin
        chk("hold_out", 80'({ov8, ir8, pack8()}), 80'({1'b1, 1'b0, hexp}));
      end
    end
    or8 = 1'b1; iv8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    if (use_hexp) chk("release_idle", 80'({ir8, ov8}), 80'({1'b1, 1'b0}));
  endtask

  task automatic run16(input logic [15:0] ta, tbv, input logic [3:0] ts, input logic tm, tc,
                       output res_t got, output int lat);
    @(negedge clk);
    a16 = ta; b16 = tbv; s16 = ts; m16 = tm; c16 = tc; iv16 = 1'b1; or16 = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk); iv16 = 1'b0;
    while (!ov16 && lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!ov16) chk("done_timeout16", 80'(ov16), 80'(1));
    got = pack16();
    or16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or16 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic [3:0] s;
    logic       m, c;
    res_t       exp;
    string      name;
  } vec_t;

  initial begin
    vec_t vecs[5];
    res_t got, r;
    int   lat;

    vecs[0] = '{8'h3C, 8'h0F, 4'b1001, 1'b0, 1'b0, mk(64'h4B, 0, 0, 0, 0), "add"};
    vecs[1] = '{8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0, mk(64'h00, 1, 0, 0, 1), "wrap"};
    vecs[2] = '{8'h05, 8'h07, 4'b0110, 1'b0, 1'b1, mk(64'hFE, 0, 0, 0, 0), "sub"};
    vecs[3] = '{8'h7F, 8'h01, 4'b1001, 1'b0, 1'b0, mk(64'h80, 0, 1, 0, 0), "ovf"};
    vecs[4] = '{8'hAA, 8'hAA, 4'b0110, 1'b1, 1'b1, mk(64'h00, 0, 0, 1, 1), "logic_xor"};

    #12;
    chk("reset8", 80'({ir8, ov8, pack8()}), 80'({1'b1, 1'b0, res_t'('0)}));
    chk("reset16", 80'({ir16, ov16, pack16()}), 80'({1'b1, 1'b0, res_t'('0)}));
    @(negedge clk);
    rst_n = 1'b1; rst16_n = 1'b1;
    chk_on = 1'b1;

    foreach (vecs[i]) begin
      r = ref_alu(8, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].s, vecs[i].m, vecs[i].c);
      chk({"model_", vecs[i].name}, 80'(r), 80'(vecs[i].exp));
      run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].c, 0, 1'b0, '0, got, lat);
      chk({"dut_", vecs[i].name}, 80'(got), 80'(vecs[i].exp));
      chk({"lat_", vecs[i].name}, 80'(lat), 80'(NIB8));
    end

    // Backpressure: result held three cycles with in_valid asserted and ignored
    run8(8'h3C, 8'h0F, 4'b1001, 1'b0, 1'b0, 3, 1'b1, mk(64'h4B, 0, 0, 0, 0), got, lat);
    chk("bp_result", 80'(got), 80'(mk(64'h4B, 0, 0, 0, 0)));

    for (int i = 0; i < 250; i++) begin
      run8(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3), 1'b0, '0, got, lat);
    end

    // Mid-operation reset on the 16-bit instance
    run16(16'h00FF, 16'h00FF, 4'b1001, 1'b0, 1'b0, got, lat);
    chk("pre16", 80'(got), 80'(mk(64'h01FE, 0, 0, 1, 0)));
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0001; s16 = 4'b1001; m16 = 1'b0; c16 = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk); iv16 = 1'b0;
    @(posedge clk);
    #2 rst16_n = 1'b0;
    #1 chk("midrun_reset16", 80'({ir16, ov16, pack16()}), 80'({1'b1, 1'b0, res_t'('0)}));
    @(negedge clk);
    rst16_n = 1'b1;
    run16(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0, got, lat);
    chk("post_reset16", 80'(got), 80'(mk(64'h2345, 0, 0, 0, 0)));
    chk("lat16", 80'(lat), 80'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
